// File: rtl/pwm_pkg.sv
// Shared constants and types for the 16-channel PWM output block.
// Optional duty shadowing is selected with PWM_DUTY_SHADOW_EN.
package pwm_pkg;

    localparam int          PWM_CNT_W        = 8;
    localparam int          PWM_CHANNELS     = 16;
    localparam logic [7:0]  DUTY_FULL        = 8'hFF;
    localparam int unsigned PRESCALE_DEFAULT = 13;

    typedef logic [PWM_CNT_W-1:0] duty_t;

    // Full-scale duty holds the line high instead of 255/256.
    function automatic logic pwm_level(input duty_t duty, input duty_t cnt);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-file side bundle for the PWM block: enables and duty in,
// pin drive and period marker out.
interface pwm_peripheral_if;
    import pwm_pkg::*;

    logic [7:0]              en_reg_out_7_0;
    logic [7:0]              en_reg_out_15_8;
    logic [7:0]              en_reg_pwm_7_0;
    logic [7:0]              en_reg_pwm_15_8;
    duty_t                   pwm_duty_cycle;
    logic [PWM_CHANNELS-1:0] out;
    logic                    period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM timebase: count, wrap strobe and a registered
// period-start pulse that stays low on the first cycle after reset.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    output duty_t o_pwm_cnt,
    output logic  o_wrap,
    output logic  o_period_start
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_pre_cnt;
    duty_t       r_pwm_cnt;
    logic        r_period_start;
    logic        w_tick;
    logic        w_wrap;

    assign w_tick = (r_pre_cnt == PRE_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == DUTY_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pre_cnt      <= w_tick ? '0 : r_pre_cnt + 16'd1;
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    assign o_pwm_cnt      = r_pwm_cnt;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM pin driver with a shared duty cycle.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at the period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    pwm_peripheral_if.slave  bus
);

    duty_t                   w_pwm_cnt;
    logic                    w_wrap;
    logic                    w_period_start;
    duty_t                   w_duty_active;
    logic                    w_pwm_raw;
    logic [PWM_CHANNELS-1:0] w_en_out;
    logic [PWM_CHANNELS-1:0] w_en_pwm;
    logic [PWM_CHANNELS-1:0] w_out_next;
    logic [PWM_CHANNELS-1:0] r_out;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .o_pwm_cnt      (w_pwm_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (w_period_start)
    );

`ifdef PWM_DUTY_SHADOW_EN
    duty_t r_duty_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
        end else if (w_wrap) begin
            r_duty_active <= bus.pwm_duty_cycle;
        end
    end

    assign w_duty_active = r_duty_active;
`else
    assign w_duty_active = bus.pwm_duty_cycle;
`endif

    assign w_pwm_raw = pwm_level(w_duty_active, w_pwm_cnt);
    assign w_en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Disabled -> 0, static mode -> 1, PWM mode -> shared waveform.
    assign w_out_next = w_en_out & (~w_en_pwm | {PWM_CHANNELS{w_pwm_raw}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = w_period_start;

endmodule
